// File: rtl/atualizador_aprovados.sv
// rtl/atualizador_aprovados.sv - serial relaxation of expanded neighbours
// Reads each valid neighbour's distance, writes improvements and pushes them to the open list.
module atualizador_aprovados #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DISTANCIA_WIDTH = 6,
  parameter int NUM_READ_PORTS  = 8,
  parameter int IDX_WIDTH       = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ea_atualizar_in,
  input  logic [NUM_READ_PORTS-1:0]              ea_vizinho_valido_in,
  input  logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]   ea_endereco_in,
  input  logic [DISTANCIA_WIDTH*NUM_READ_PORTS-1:0] ea_distancia_in,
  input  logic [ADDR_WIDTH-1:0]                  ea_anterior_in,
  output logic                                   aa_atualizar_ready_out,
  output logic                                   aa_distancia_rd_enable_out,
  output logic [ADDR_WIDTH-1:0]                  aa_distancia_rd_addr_out,
  input  logic                                   gd_distancia_ready_in,
  input  logic [DISTANCIA_WIDTH-1:0]             gd_distancia_rd_data_in,
  output logic                                   aa_wr_enable_out,
  output logic [ADDR_WIDTH-1:0]                  aa_wr_addr_out,
  output logic [DISTANCIA_WIDTH-1:0]             aa_wr_distancia_out,
  output logic [ADDR_WIDTH-1:0]                  aa_wr_anterior_out,
  output logic                                   aa_push_valid_out,
  output logic [ADDR_WIDTH-1:0]                  aa_push_addr_out,
  output logic [DISTANCIA_WIDTH-1:0]             aa_push_distancia_out,
  input  logic                                   lv_push_ready_in,
  output logic                                   aa_ocupado_out,
  output logic                                   aa_pronto_out
);

  localparam int A = ADDR_WIDTH;
  localparam int D = DISTANCIA_WIDTH;
  localparam int N = NUM_READ_PORTS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECIONAR,
    ST_LER_DISTANCIA,
    ST_COMPARAR,
    ST_ESCREVER,
    ST_EMPILHAR,
    ST_FINALIZAR
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [N-1:0]       pendente_q, pendente_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [A*N-1:0]     enderecos_q, enderecos_d;
  logic [D*N-1:0]     distancias_q, distancias_d;
  logic [A-1:0]       anterior_q, anterior_d;
  logic [D-1:0]       atual_q, atual_d;
  logic               ocupado_q, ocupado_d;
  logic               rd_enable_q;

  logic [A-1:0]       end_sel;
  logic [D-1:0]       dist_sel;
  logic [N-1:0]       pendente_novo;
  logic [IDX_WIDTH-1:0] idx_menor;

  assign end_sel  = enderecos_q[A*int'(idx_q) +: A];
  assign dist_sel = distancias_q[D*int'(idx_q) +: D];

  // Inexistent nodes and infinite candidates can never improve anything, so drop them up front.
  always_comb begin
    pendente_novo = '0;
    for (int i = 0; i < N; i++) begin
      pendente_novo[i] = ea_vizinho_valido_in[i]
                       & ~(&ea_endereco_in[A*i +: A])
                       & ~(&ea_distancia_in[D*i +: D]);
    end
  end

  always_comb begin
    idx_menor = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pendente_q[i]) idx_menor = IDX_WIDTH'(i);
    end
  end

  always_comb begin
    estado_d     = estado_q;
    pendente_d   = pendente_q;
    idx_d        = idx_q;
    enderecos_d  = enderecos_q;
    distancias_d = distancias_q;
    anterior_d   = anterior_q;
    atual_d      = atual_q;
    ocupado_d    = ocupado_q;
    case (estado_q)
      ST_IDLE: begin
        if (ea_atualizar_in) begin
          enderecos_d  = ea_endereco_in;
          distancias_d = ea_distancia_in;
          anterior_d   = ea_anterior_in;
          pendente_d   = pendente_novo;
          ocupado_d    = 1'b1;
          estado_d     = ST_SELECIONAR;
        end
      end
      ST_SELECIONAR: begin
        if (pendente_q == '0) begin
          estado_d = ST_FINALIZAR;
        end else begin
          idx_d                 = idx_menor;
          pendente_d[idx_menor] = 1'b0;
          estado_d              = ST_LER_DISTANCIA;
        end
      end
      ST_LER_DISTANCIA: begin
        if (gd_distancia_ready_in) begin
          atual_d  = gd_distancia_rd_data_in;
          estado_d = ST_COMPARAR;
        end
      end
      ST_COMPARAR: estado_d = (dist_sel < atual_q) ? ST_ESCREVER : ST_SELECIONAR;
      ST_ESCREVER: estado_d = ST_EMPILHAR;
      ST_EMPILHAR: begin
        if (lv_push_ready_in) estado_d = ST_SELECIONAR;
      end
      ST_FINALIZAR: begin
        ocupado_d = 1'b0;
        estado_d  = ST_IDLE;
      end
      default: estado_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q     <= ST_IDLE;
      pendente_q   <= '0;
      idx_q        <= '0;
      enderecos_q  <= '0;
      distancias_q <= '0;
      anterior_q   <= '0;
      atual_q      <= '0;
      ocupado_q    <= 1'b0;
      rd_enable_q  <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      pendente_q   <= pendente_d;
      idx_q        <= idx_d;
      enderecos_q  <= enderecos_d;
      distancias_q <= distancias_d;
      anterior_q   <= anterior_d;
      atual_q      <= atual_d;
      ocupado_q    <= ocupado_d;
      // The read request stays up for as long as the read state is held waiting for data.
      rd_enable_q  <= (estado_d == ST_LER_DISTANCIA);
    end
  end

  assign aa_atualizar_ready_out     = (estado_q == ST_IDLE);
  assign aa_distancia_rd_enable_out = rd_enable_q;
  assign aa_distancia_rd_addr_out   = (estado_q == ST_LER_DISTANCIA) ? end_sel : '0;
  assign aa_wr_enable_out           = (estado_q == ST_ESCREVER);
  assign aa_wr_addr_out             = aa_wr_enable_out ? end_sel : '0;
  assign aa_wr_distancia_out        = aa_wr_enable_out ? dist_sel : '0;
  assign aa_wr_anterior_out         = aa_wr_enable_out ? anterior_q : '0;
  assign aa_push_valid_out          = (estado_q == ST_EMPILHAR);
  assign aa_push_addr_out           = aa_push_valid_out ? end_sel : '0;
  assign aa_push_distancia_out      = aa_push_valid_out ? dist_sel : '0;
  assign aa_ocupado_out             = ocupado_q;
  assign aa_pronto_out              = (estado_q == ST_FINALIZAR);

endmodule

// File: tb/tb_atualizador_aprovados.sv
// tb/tb_atualizador_aprovados.sv - scoreboard bench for atualizador_aprovados
module tb_atualizador_aprovados;

  logic        clk = 0;
  logic        rst = 1;
  logic        ea_atualizar = 0;
  logic [7:0]  ea_valido = 0;
  logic [79:0] ea_endereco = 0;
  logic [47:0] ea_distancia = 0;
  logic [9:0]  ea_anterior = 0;
  logic        ready_o, rd_en, wr_en, push_valid, ocupado, pronto;
  logic [9:0]  rd_addr, wr_addr, wr_ant, push_addr;
  logic [5:0]  wr_dist, push_dist;
  logic        gd_ready = 0;
  logic [5:0]  gd_data = 0;
  logic        lv_ready = 0;

  atualizador_aprovados dut (
    .clk(clk), .rst(rst),
    .ea_atualizar_in(ea_atualizar), .ea_vizinho_valido_in(ea_valido),
    .ea_endereco_in(ea_endereco), .ea_distancia_in(ea_distancia), .ea_anterior_in(ea_anterior),
    .aa_atualizar_ready_out(ready_o),
    .aa_distancia_rd_enable_out(rd_en), .aa_distancia_rd_addr_out(rd_addr),
    .gd_distancia_ready_in(gd_ready), .gd_distancia_rd_data_in(gd_data),
    .aa_wr_enable_out(wr_en), .aa_wr_addr_out(wr_addr),
    .aa_wr_distancia_out(wr_dist), .aa_wr_anterior_out(wr_ant),
    .aa_push_valid_out(push_valid), .aa_push_addr_out(push_addr),
    .aa_push_distancia_out(push_dist), .lv_push_ready_in(lv_ready),
    .aa_ocupado_out(ocupado), .aa_pronto_out(pronto)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [5:0] mem [0:1023];
  logic [5:0] ref_mem [0:1023];
  logic [9:0]  exp_rd [$];
  logic [25:0] exp_wr [$];
  logic [15:0] exp_push [$];
  int exp_pronto = 0;
  bit rd_hold = 0;
  int push_stall = 0;

  // Reference: each surviving neighbour in index order is read; strictly smaller candidate wins.
  task automatic modelo(input logic [7:0] m, input logic [79:0] ad, input logic [47:0] di,
                        input logic [9:0] ant);
    for (int i = 0; i < 8; i++) begin
      logic [9:0] a;
      logic [5:0] d;
      a = ad[10*i +: 10];
      d = di[6*i +: 6];
      if (m[i] && a != 10'h3FF && d != 6'h3F) begin
        exp_rd.push_back(a);
        if (d < ref_mem[a]) begin
          ref_mem[a] = d;
          exp_wr.push_back({a, d, ant});
          exp_push.push_back({a, d});
        end
      end
    end
    exp_pronto++;
  endtask

  task automatic setmem(input int a, input logic [5:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic start_job(input logic [7:0] m, input logic [79:0] ad, input logic [47:0] di,
                           input logic [9:0] ant);
    int n;
    modelo(m, ad, di, ant);
    @(negedge clk);
    ea_valido = m; ea_endereco = ad; ea_distancia = di; ea_anterior = ant;
    ea_atualizar = 1;
    n = 0;
    while (!ready_o && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!ready_o) begin failures++; $display("FAIL start_timeout ready=%0b required=1", ready_o); end
    @(negedge clk);
    ea_atualizar = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!ready_o && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (!ready_o) begin failures++; $display("FAIL done_timeout ready=%0b required=1", ready_o); end
  endtask

  task automatic job(input logic [7:0] m, input logic [79:0] ad, input logic [47:0] di,
                     input logic [9:0] ant);
    start_job(m, ad, di, ant);
    wait_done();
  endtask

  task automatic check_reset(input string nome);
    logic [57:0] got;
    got = {ready_o, rd_en, rd_addr, wr_en, wr_addr, wr_dist, wr_ant,
           push_valid, push_addr, push_dist, ocupado, pronto};
    checks++;
    if (got != {1'b1, 57'd0}) begin
      failures++;
      $display("FAIL %s outputs=%h required=%h", nome, got, {1'b1, 57'd0});
    end
  endtask

  // Memory and open-list responders, driven away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en && !rst) mem[wr_addr] = wr_dist;
      gd_ready = rd_en && !rd_hold && ($urandom_range(0, 2) != 0);
      gd_data  = mem[rd_addr];
      if (push_valid && push_stall > 0) begin
        lv_ready = 0;
        push_stall--;
      end else begin
        lv_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  initial begin
    bit rd_prev, wr_prev, push_prev;
    logic [15:0] push_held;
    logic [9:0]  e_rd;
    logic [25:0] e_wr;
    logic [15:0] e_push;
    rd_prev = 0; wr_prev = 0; push_prev = 0; push_held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_prev = 0; wr_prev = 0; push_prev = 0;
        continue;
      end
      checks++;
      if (ready_o == ocupado) begin
        failures++; $display("FAIL ready_vs_ocupado ready=%0b ocupado=%0b", ready_o, ocupado);
      end
      if (rd_en && !rd_prev) begin
        checks++;
        if (exp_rd.size() == 0) begin
          failures++; $display("FAIL rd_unexpected addr=%0h required=none", rd_addr);
        end else begin
          e_rd = exp_rd.pop_front();
          if (rd_addr != e_rd) begin
            failures++; $display("FAIL rd_addr got=%0h required=%0h", rd_addr, e_rd);
          end
        end
      end
      if (wr_en) begin
        checks++;
        if (wr_prev) begin
          failures++; $display("FAIL wr_pulse_width wr_enable=1 two cycles required=1 cycle");
        end else if (exp_wr.size() == 0) begin
          failures++; $display("FAIL wr_unexpected addr=%0h dist=%0h required=none", wr_addr, wr_dist);
        end else begin
          e_wr = exp_wr.pop_front();
          if ({wr_addr, wr_dist, wr_ant} != e_wr) begin
            failures++;
            $display("FAIL wr_data got=%h required=%h", {wr_addr, wr_dist, wr_ant}, e_wr);
          end
        end
      end
      if (push_valid && !push_prev) begin
        checks++;
        push_held = {push_addr, push_dist};
        if (exp_push.size() == 0) begin
          failures++; $display("FAIL push_unexpected got=%h required=none", push_held);
        end else begin
          e_push = exp_push.pop_front();
          if (push_held != e_push) begin
            failures++; $display("FAIL push_data got=%h required=%h", push_held, e_push);
          end
        end
      end else if (push_valid) begin
        checks++;
        if ({push_addr, push_dist} != push_held) begin
          failures++;
          $display("FAIL push_stable got=%h required=%h", {push_addr, push_dist}, push_held);
        end
      end
      if (push_valid && rd_en) begin
        checks++; failures++;
        $display("FAIL read_during_push rd_enable=1 required=0");
      end
      if (pronto) begin
        checks++;
        if (exp_pronto == 0 || exp_rd.size() != 0 || exp_wr.size() != 0 || exp_push.size() != 0) begin
          failures++;
          $display("FAIL pronto_drain jobs=%0d rd=%0d wr=%0d push=%0d required=pending job,0,0,0",
                   exp_pronto, exp_rd.size(), exp_wr.size(), exp_push.size());
        end
        if (exp_pronto > 0) exp_pronto--;
      end
      rd_prev = rd_en; wr_prev = wr_en; push_prev = push_valid;
    end
  end

  initial begin
    logic [79:0] ad;
    logic [47:0] di;
    int n;
    for (int a = 0; a < 1024; a++) setmem(a, (a < 32) ? 6'($urandom_range(0, 63)) : 6'h3F);
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst = 0;

    // 1: single improvement
    setmem(5, 6'h3F);
    ad = 0; di = 0; ad[9:0] = 10'd5; di[5:0] = 6'd3;
    job(8'h01, ad, di, 10'd77);
    // 2: equal distance is not an update
    setmem(6, 6'd7);
    ad = 0; di = 0; ad[9:0] = 10'd6; di[5:0] = 6'd7;
    job(8'h01, ad, di, 10'd12);
    // 3: sparse mask, ordering
    for (int i = 0; i < 8; i++) begin
      setmem(100 + i, 6'h3F); ad[10*i +: 10] = 10'(100 + i); di[6*i +: 6] = 6'(i + 1);
    end
    job(8'hA5, ad, di, 10'd33);
    // 4: inexistent address and infinite candidate filtered
    for (int i = 0; i < 8; i++) begin
      setmem(200 + i, 6'h3F); ad[10*i +: 10] = 10'(200 + i); di[6*i +: 6] = 6'(i + 2);
    end
    ad[30 +: 10] = 10'h3FF; di[36 +: 6] = 6'h3F;
    job(8'hFF, ad, di, 10'd44);
    // 5: open-list backpressure
    setmem(300, 6'h3F); setmem(301, 6'h3F);
    ad = 0; di = 0; ad[9:0] = 10'd300; ad[19:10] = 10'd301; di[5:0] = 6'd1; di[11:6] = 6'd2;
    push_stall = 10;
    job(8'h03, ad, di, 10'd55);
    // 6: reset while waiting for a read, then a clean rerun
    setmem(400, 6'h3F);
    ad = 0; di = 0; ad[9:0] = 10'd400; di[5:0] = 6'd9;
    rd_hold = 1;
    start_job(8'h01, ad, di, 10'd66);
    n = 0;
    while (!rd_en && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!rd_en) begin failures++; $display("FAIL rd_wait_timeout rd_enable=0 required=1"); end
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check_reset("reset_mid_read");
    exp_rd.delete(); exp_wr.delete(); exp_push.delete(); exp_pronto = 0;
    for (int a = 0; a < 1024; a++) ref_mem[a] = mem[a];
    rst = 0; rd_hold = 0;
    job(8'h01, ad, di, 10'd67);

    // Randomized jobs over a small address space so neighbours collide across jobs.
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 8; i++) begin
        ad[10*i +: 10] = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 31));
        di[6*i +: 6]   = 6'($urandom_range(0, 63));
      end
      job(8'($urandom), ad, di, 10'($urandom_range(0, 1022)));
    end

    repeat (5) @(negedge clk);
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0 || exp_push.size() != 0 || exp_pronto != 0) begin
      failures++;
      $display("FAIL final_drain rd=%0d wr=%0d push=%0d pronto=%0d required=0,0,0,0",
               exp_rd.size(), exp_wr.size(), exp_push.size(), exp_pronto);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
